// File: rtl/output_deskew_pkg.sv
`default_nettype none
// ============================================================================
// Module   : output_deskew_pkg
// Brief    : Shared lane count, deskew depth and aligned-sample width helper.
// Revision : 1.0
// ============================================================================
package output_deskew_pkg;

    localparam int c_NUM_LANES    = 5;
    localparam int c_DESKEW_DEPTH = 4;

    // Packed aligned sample: five weight lanes plus the error lane.
    function automatic int sample_width(input int data_length);
        return (c_NUM_LANES + 1) * data_length;
    endfunction

endpackage
`default_nettype wire

// File: rtl/deskew_fifo.sv
`default_nettype none
// ============================================================================
// Module   : deskew_fifo
// Brief    : Output buffer with registered head; accepts push on full with pop.
// Revision : 1.0
// ============================================================================
module deskew_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW:0]    r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic [c_AW-1:0]  w_rd_next;

    assign w_full    = (r_count == c_FULL);
    assign w_empty   = (r_count == '0);
    assign w_pop     = pop & ~w_empty & ~flush;
    assign w_push    = push & (~w_full | w_pop) & ~flush;
    assign w_rd_next = r_rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Head mirrors mem[rd_ptr]; refresh it only when the head entry changes.
            if (w_push && (w_empty || (w_pop && r_count == 1))) begin
                r_head <= push_data;
            end else if (w_pop && r_count > 1) begin
                r_head <= r_mem[w_rd_next];
            end
        end
    end

    assign pop_data = r_head;
    assign full     = w_full;
    assign empty    = w_empty;

endmodule
`default_nettype wire

// File: rtl/output_deskew.sv
`default_nettype none
// ============================================================================
// Module   : output_deskew
// Brief    : Realigns staggered systolic lanes and buffers aligned samples.
//            Define DESKEW_COUNT_EN to enable the delivered-sample counter.
// Revision : 1.0
// ============================================================================
module output_deskew
    import output_deskew_pkg::*;
#(
    parameter int DATA_LENGTH = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    input  logic [DATA_LENGTH-1:0] wx_in1,
    input  logic [DATA_LENGTH-1:0] wx_in2,
    input  logic [DATA_LENGTH-1:0] wx_in3,
    input  logic [DATA_LENGTH-1:0] wx_in4,
    input  logic [DATA_LENGTH-1:0] wx_in5,
    input  logic [DATA_LENGTH-1:0] error_in,
    input  logic                   flush,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [DATA_LENGTH-1:0] wxout1,
    output logic [DATA_LENGTH-1:0] wxout2,
    output logic [DATA_LENGTH-1:0] wxout3,
    output logic [DATA_LENGTH-1:0] wxout4,
    output logic [DATA_LENGTH-1:0] wxout5,
    output logic [DATA_LENGTH-1:0] error,
    output logic                   overflow,
    output logic [15:0]            sample_count
);

    localparam int c_SAMPLE_W = sample_width(DATA_LENGTH);

    logic [DATA_LENGTH-1:0]    w_lane_in  [c_NUM_LANES];
    logic [DATA_LENGTH-1:0]    w_aligned  [c_NUM_LANES];
    logic [c_DESKEW_DEPTH-1:0] r_vpipe;
    logic                      w_aligned_valid;
    logic [c_SAMPLE_W-1:0]     w_push_data;
    logic [c_SAMPLE_W-1:0]     w_head;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_pop;
    logic                      r_overflow;

    assign w_lane_in[0] = wx_in1;
    assign w_lane_in[1] = wx_in2;
    assign w_lane_in[2] = wx_in3;
    assign w_lane_in[3] = wx_in4;
    assign w_lane_in[4] = wx_in5;

    // Lane k+1 arrives k cycles late, so it needs DEPTH-k stages to line up.
    for (genvar k = 0; k < c_NUM_LANES; k++) begin : g_lane
        localparam int c_STAGES = c_DESKEW_DEPTH - k;
        if (c_STAGES == 0) begin : g_pass
            assign w_aligned[k] = w_lane_in[k];
        end else begin : g_dly
            logic [DATA_LENGTH-1:0] r_dly [c_STAGES];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < c_STAGES; s++) begin
                        r_dly[s] <= '0;
                    end
                end else begin
                    r_dly[0] <= w_lane_in[k];
                    for (int s = 1; s < c_STAGES; s++) begin
                        r_dly[s] <= r_dly[s-1];
                    end
                end
            end
            assign w_aligned[k] = r_dly[c_STAGES-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vpipe <= '0;
        end else if (flush) begin
            r_vpipe <= '0;
        end else begin
            r_vpipe <= {r_vpipe[c_DESKEW_DEPTH-2:0], valid_in};
        end
    end

    assign w_aligned_valid = r_vpipe[c_DESKEW_DEPTH-1];
    assign w_push_data     = {w_aligned[0], w_aligned[1], w_aligned[2],
                              w_aligned[3], w_aligned[4], error_in};
    assign w_pop           = ~w_empty & out_ready;

    deskew_fifo #(
        .WIDTH (c_SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (w_aligned_valid),
        .push_data (w_push_data),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (!flush && w_aligned_valid && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef DESKEW_COUNT_EN
    logic [15:0] r_sample_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample_count <= '0;
        end else if (w_pop && !flush) begin
            r_sample_count <= r_sample_count + 1'b1;
        end
    end

    assign sample_count = r_sample_count;
`else
    assign sample_count = '0;
`endif

    assign out_valid = ~w_empty;
    assign wxout1    = w_head[5*DATA_LENGTH +: DATA_LENGTH];
    assign wxout2    = w_head[4*DATA_LENGTH +: DATA_LENGTH];
    assign wxout3    = w_head[3*DATA_LENGTH +: DATA_LENGTH];
    assign wxout4    = w_head[2*DATA_LENGTH +: DATA_LENGTH];
    assign wxout5    = w_head[1*DATA_LENGTH +: DATA_LENGTH];
    assign error     = w_head[0 +: DATA_LENGTH];
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_output_deskew.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_deskew
// Brief    : Directed self-checking bench for output_deskew (8-bit, depth 4).
// Revision : 1.0
// ============================================================================
module tb_output_deskew;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_in;
    logic [7:0] wx_in1, wx_in2, wx_in3, wx_in4, wx_in5, error_in;
    logic       flush;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] wxout1, wxout2, wxout3, wxout4, wxout5, error;
    logic       overflow;
    logic [15:0] sample_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit         sv [0:1023];
    logic [7:0] sb [0:1023];

    output_deskew #(.DATA_LENGTH(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in),
        .wx_in1(wx_in1), .wx_in2(wx_in2), .wx_in3(wx_in3),
        .wx_in4(wx_in4), .wx_in5(wx_in5), .error_in(error_in),
        .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
        .wxout1(wxout1), .wxout2(wxout2), .wxout3(wxout3),
        .wxout4(wxout4), .wxout5(wxout5), .error(error),
        .overflow(overflow), .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    // Lane k of the sample started at cycle s is base+k, error is base+DE.
    function automatic logic [7:0] lane(input int c, input int k);
        int s = c - (k - 1);
        logic [7:0] v = '0;
        if (s >= 0 && sv[s]) v = sb[s] + 8'(k);
        return v;
    endfunction

    function automatic logic [7:0] err_lane(input int c);
        int s = c - 4;
        logic [7:0] v = '0;
        if (s >= 0 && sv[s]) v = sb[s] + 8'hDE;
        return v;
    endfunction

    function automatic logic [47:0] exp_vec(input logic [7:0] b);
        return {b + 8'd1, b + 8'd2, b + 8'd3, b + 8'd4, b + 8'd5, b + 8'hDE};
    endfunction

    function automatic logic [15:0] exp_sc(input int n);
`ifdef DESKEW_COUNT_EN
        return 16'(n);
`else
        return 16'(0 * n);
`endif
    endfunction

    task automatic drive_cycle();
        valid_in = sv[cyc];
        wx_in1   = lane(cyc, 1);
        wx_in2   = lane(cyc, 2);
        wx_in3   = lane(cyc, 3);
        wx_in4   = lane(cyc, 4);
        wx_in5   = lane(cyc, 5);
        error_in = err_lane(cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        drive_cycle();
    endtask

    task automatic go_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic sched(input int at, input logic [7:0] base);
        sv[at] = 1'b1;
        sb[at] = base;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] out_vec();
        return {wxout1, wxout2, wxout3, wxout4, wxout5, error};
    endfunction

    task automatic chk_idle(input string tag, input int n);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_data"}, 64'(out_vec()), 64'd0);
        chk({tag, "_ovf"}, 64'(overflow), 64'd0);
        chk({tag, "_cnt"}, 64'(sample_count), 64'(exp_sc(n)));
    endtask

    initial begin
        int t0;
        int cnt;
        bit seen;
        for (int i = 0; i < 1024; i++) begin
            sv[i] = 1'b0;
            sb[i] = '0;
        end
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive_cycle();
        #1;
        chk_idle("reset_async", 0);
        step(); step();
        chk_idle("reset_held", 0);
        rst = 1'b0;
        step();
        chk_idle("after_reset", 0);

        // Single sample: out_valid exactly five cycles after valid_in.
        out_ready = 1'b1;
        cnt = 0;
        t0 = cyc + 1;
        sched(t0, 8'h10);
        go_to(t0 + 4);
        chk("single_early", 64'(out_valid), 64'd0);
        step();
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_data", 64'(out_vec()), 64'(48'h11_12_13_14_15_EE));
        step();
        cnt++;
        chk("single_drained", 64'(out_valid), 64'd0);

        // Ten back-to-back samples with a ready consumer.
        t0 = cyc + 1;
        for (int i = 0; i < 10; i++) sched(t0 + i, 8'(8'h20 + 8 * i));
        for (int i = 0; i < 10; i++) begin
            go_to(t0 + 5 + i);
            chk($sformatf("b2b_valid%0d", i), 64'(out_valid), 64'd1);
            chk($sformatf("b2b_data%0d", i), 64'(out_vec()), 64'(exp_vec(8'(8'h20 + 8 * i))));
        end
        step();
        cnt += 10;
        chk("b2b_drained", 64'(out_valid), 64'd0);
        chk("b2b_ovf", 64'(overflow), 64'd0);
        chk("b2b_cnt", 64'(sample_count), 64'(exp_sc(cnt)));

        // Backpressure: four fill the buffer, the fifth is dropped.
        out_ready = 1'b0;
        t0 = cyc + 1;
        for (int i = 0; i < 5; i++) sched(t0 + i, 8'(8'h80 + 8 * i));
        go_to(t0 + 5);
        chk("bp_head", 64'(out_vec()), 64'(exp_vec(8'h80)));
        go_to(t0 + 8);
        chk("bp_ovf_before", 64'(overflow), 64'd0);
        step();
        chk("bp_ovf_set", 64'(overflow), 64'd1);
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_data", 64'(out_vec()), 64'(exp_vec(8'h80)));
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_drain%0d", i), 64'(out_vec()), 64'(exp_vec(8'(8'h80 + 8 * i))));
            step();
        end
        cnt += 4;
        chk("bp_empty", 64'(out_valid), 64'd0);
        chk("bp_ovf_sticky", 64'(overflow), 64'd1);
        chk("bp_cnt", 64'(sample_count), 64'(exp_sc(cnt)));

        // Flush with three samples buffered; overflow stays set.
        out_ready = 1'b0;
        t0 = cyc + 1;
        for (int i = 0; i < 3; i++) sched(t0 + i, 8'(8'hA0 + 8 * i));
        go_to(t0 + 7);
        chk("fl_before", 64'(out_vec()), 64'(exp_vec(8'hA0)));
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_ovf", 64'(overflow), 64'd1);
        out_ready = 1'b1;
        sched(t0 + 9, 8'hC0);
        go_to(t0 + 13);
        chk("fl_after_early", 64'(out_valid), 64'd0);
        step();
        chk("fl_after_valid", 64'(out_valid), 64'd1);
        chk("fl_after_data", 64'(out_vec()), 64'(exp_vec(8'hC0)));
        step();
        cnt++;
        chk("fl_after_cnt", 64'(sample_count), 64'(exp_sc(cnt)));

        // Reset clears sticky overflow and counter.
        rst = 1'b1;
        step();
        rst = 1'b0;
        cnt = 0;
        step();
        chk_idle("rst2", 0);

        // Full buffer with push and pop in the same cycle.
        out_ready = 1'b0;
        t0 = cyc + 1;
        for (int i = 0; i < 4; i++) sched(t0 + i, 8'(8'h30 + 8 * i));
        sched(t0 + 6, 8'h70);
        go_to(t0 + 9);
        chk("pp_full_head", 64'(out_vec()), 64'(exp_vec(8'h30)));
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        cnt++;
        chk("pp_ovf", 64'(overflow), 64'd0);
        chk("pp_head", 64'(out_vec()), 64'(exp_vec(8'h38)));
        step();
        out_ready = 1'b1;
        chk("pp_d1", 64'(out_vec()), 64'(exp_vec(8'h38)));
        step();
        chk("pp_d2", 64'(out_vec()), 64'(exp_vec(8'h40)));
        step();
        chk("pp_d3", 64'(out_vec()), 64'(exp_vec(8'h48)));
        step();
        chk("pp_d4", 64'(out_vec()), 64'(exp_vec(8'h70)));
        step();
        cnt += 4;
        chk("pp_empty", 64'(out_valid), 64'd0);
        chk("pp_cnt", 64'(sample_count), 64'(exp_sc(cnt)));

        // Reset two cycles after valid_in: the sample must never appear.
        t0 = cyc + 1;
        sched(t0, 8'h50);
        go_to(t0 + 2);
        rst = 1'b1;
        #1;
        chk_idle("mid_rst_async", 0);
        step();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        chk("mid_rst_no_out", 64'(seen), 64'd0);
        chk_idle("mid_rst_final", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
